uart_loader: RTL and testbench
==============================

# uart_loader

Serial boot loader that sits upstream of the instruction-memory MemoryDriver write port. It receives an 8N1 UART byte stream and parses a length-prefixed image. It assembles little-endian 32-bit words and issues one single-cycle write per word into instruction memory. While the load runs it holds `o_busy` high, so the top level keeps the core in reset until the image is in place.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); minimum 4.
- `MLEN`, 1024: target memory size in bytes; must match the MemoryDriver `MLEN`.
- `MALEN`, `$clog2(MLEN)`: byte-address width.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rstn` in 1: synchronous, active-low reset.
- `i_rx` in 1: UART receive line, asynchronous, idles high.
- `i_arm` in 1: single-cycle pulse that starts a load; ignored while `o_busy`=1.
- `o_wvalid` out 1: single-cycle memory write strobe.
- `o_waddr` out MALEN: byte address of the word being written, 4-aligned.
- `o_wdata` out 32: word being written.
- `o_busy` out 1: high from the accepted `i_arm` until the load ends.
- `o_done` out 1: single-cycle pulse on successful completion.
- `o_frame_err` out 1: single-cycle pulse when a received stop bit is 0.

## Operation
Reset values: every output is 0, both FSMs are in their idle state, and all counters are 0.

**Input sync**
- `i_rx` passes through a 2-flop synchronizer to give `rx_s`.

**RX FSM** (IDLE, START, DATA, STOP)
- IDLE -> START: `rx_s`=0 is seen; the bit counter loads `CLKS_PER_BIT/2 - 1`.
- START -> DATA: counter expires and `rx_s` is still 0.
- START -> IDLE: counter expires and `rx_s`=1 (glitch; nothing is emitted).
- DATA: samples 8 bits LSB-first, each after `CLKS_PER_BIT` cycles. After the 8th bit it moves to STOP.
- STOP: samples once after `CLKS_PER_BIT` cycles.
  - If `rx_s`=1, it pulses internal `byte_valid` with the byte.
  - If `rx_s`=0, it pulses `o_frame_err`.
  - It returns to IDLE in either case.
- The RX FSM always runs. Bytes that arrive while the load FSM is idle are discarded.

**Load FSM** (IDLE, LEN0, LEN1, DATA, CSUM, DONE)
- IDLE: an `i_arm` pulse moves it to LEN0, sets `o_busy`=1, and clears the address, byte index and word count.
- LEN0/LEN1: receive the 16-bit word count N, low byte first.
- After LEN1:
  - N=0 goes to CSUM when checksum is compiled in, otherwise to DONE.
  - N>0 goes to DATA.
- DATA: each byte fills lane `idx` of the word buffer, lanes 0..3, little-endian.
  - On the 4th byte, `o_wvalid`=1 with the assembled word and the current `o_waddr`.
  - `o_waddr` then increments by 4 and N decrements.
  - When N reaches 0 the FSM goes to CSUM or DONE.
- CSUM: present only with the macro (see Configuration).
- DONE: pulses `o_done` for one cycle, clears `o_busy`, and returns to IDLE.
- Frame error while `o_busy`=1 aborts the load:
  - The FSM goes to IDLE and `o_busy` clears.
  - There is no `o_done` pulse.
  - The partial word is discarded.
  - Words already written stay in memory.
- Address wrap: `o_waddr` is MALEN bits wide and wraps from MLEN-4 to 0. N greater than MLEN/4 overwrites from address 0.
- Reset during a load: everything returns to reset values; no write is issued for a partial word.

## Timing
- `byte_valid` occurs the cycle after the stop-bit sample. A full frame takes about 9.5 × `CLKS_PER_BIT` cycles from the falling edge of the start bit.
- `o_wvalid` is registered: asserted the cycle after the 4th `byte_valid` of a word, for exactly one cycle.
- `o_waddr` and `o_wdata` are stable while `o_wvalid`=1. `o_waddr` takes its incremented value the following cycle.
- `o_done` is asserted the cycle after the final `o_wvalid`, or after the checksum byte when checksum is compiled in.
- `o_busy` falls in the same cycle that `o_done` is asserted.
- `i_arm` is sampled only when the load FSM is in IDLE. If `i_arm` coincides with `o_done`, it is ignored.
- The memory write port needs no ready signal; back-to-back writes are at least 4 byte-times apart.

## Configuration
- Macro `UART_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of all payload bytes (header excluded) is kept.
  - One trailing checksum byte is received in state CSUM.
  - Match: go to DONE.
  - Mismatch: pulse output `o_csum_err` (extra port, reset 0), clear `o_busy`, return to IDLE, no `o_done`.
- Undefined:
  - No CSUM state and no `o_csum_err` port.
  - DONE follows the last word directly.

## Test plan
- `CLKS_PER_BIT`=8. Arm, then send 02 00 | 13 00 00 00 | 6F 00 00 00.
  - Expect writes (0x000, 0x00000013) then (0x004, 0x0000006F).
  - Expect `o_done` one cycle after the 2nd write.
  - With checksum, send 7C as the trailing byte.
- Send bytes with no `i_arm` -> no `o_wvalid`, `o_busy` stays 0.
- Arm, send 01 00 AA, then a frame whose stop bit is 0.
  - Expect `o_frame_err` pulse, `o_busy`=0, no write, no `o_done`.
- `MLEN`=16, N=5 words -> 5th write lands at `o_waddr`=0x0.
- Assert `rstn`=0 mid-word, then release and arm again -> first write goes to 0x000 and contains only new bytes.
- `UART_LOADER_CHECKSUM_EN`: N=1, word 11 22 33 44, checksum byte 00 (correct value 44).
  - Expect 1 write, `o_csum_err` pulse, no `o_done`.

Source files
------------

// File: rtl/uart_loader.sv
// UART boot loader: 8N1 receiver feeding a length-prefixed, little-endian word writer.
// Optional trailing XOR checksum is compiled in with `define UART_LOADER_CHECKSUM_EN.
module uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MLEN         = 1024,
    parameter int MALEN        = $clog2(MLEN)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_rx,
    input  logic             i_arm,
    output logic             o_wvalid,
    output logic [MALEN-1:0] o_waddr,
    output logic [31:0]      o_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_frame_err
`ifdef UART_LOADER_CHECKSUM_EN
    ,
    output logic             o_csum_err
`endif
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [MALEN-1:0] LAST_ADDR = MALEN'(MLEN - 4);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        LD_IDLE, LD_LEN0, LD_LEN1, LD_DATA, LD_DONE
`ifdef UART_LOADER_CHECKSUM_EN
        , LD_CSUM
`endif
    } ld_state_t;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam ld_state_t LD_TAIL = LD_CSUM;
`else
    localparam ld_state_t LD_TAIL = LD_DONE;
`endif

    // ---------------- receiver ----------------
    logic             r_rx_meta, r_rx_s;
    rx_state_t        r_rx_state, w_rx_next;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt;
    logic [2:0]       r_bit_idx, w_bit_idx;
    logic [7:0]       r_shift, w_shift;
    logic             r_byte_valid, w_byte_valid;
    logic             r_frame_err, w_frame_err;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        w_rx_next    = r_rx_state;
        w_bit_cnt    = r_bit_cnt - CNT_W'(1);
        w_bit_idx    = r_bit_idx;
        w_shift      = r_shift;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                w_bit_cnt = r_bit_cnt;
                if (!r_rx_s) begin
                    w_rx_next = RX_START;
                    w_bit_cnt = HALF_BIT;
                end
            end
            RX_START: if (r_bit_cnt == '0) begin
                if (!r_rx_s) begin
                    w_rx_next = RX_DATA;
                    w_bit_cnt = FULL_BIT;
                    w_bit_idx = 3'd0;
                end else begin
                    w_rx_next = RX_IDLE;   // glitch shorter than half a bit
                    w_bit_cnt = '0;
                end
            end
            RX_DATA: if (r_bit_cnt == '0) begin
                w_shift   = {r_rx_s, r_shift[7:1]};
                w_bit_cnt = FULL_BIT;
                if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
                else                   w_bit_idx = r_bit_idx + 3'd1;
            end
            RX_STOP: if (r_bit_cnt == '0) begin
                w_byte_valid = r_rx_s;
                w_frame_err  = !r_rx_s;
                w_rx_next    = RX_IDLE;
                w_bit_cnt    = '0;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_s       <= r_rx_meta;
            r_rx_state   <= w_rx_next;
            r_bit_cnt    <= w_bit_cnt;
            r_bit_idx    <= w_bit_idx;
            r_shift      <= w_shift;
            r_byte_valid <= w_byte_valid;
            r_frame_err  <= w_frame_err;
        end
    end

    // ---------------- image loader ----------------
    ld_state_t        r_ld_state, w_ld_next;
    logic [15:0]      r_count, w_count;
    logic [1:0]       r_idx, w_idx;
    logic [23:0]      r_wbuf, w_wbuf;
    logic [MALEN-1:0] r_waddr, w_waddr, w_waddr_inc;
    logic [31:0]      r_wdata, w_wdata;
    logic             r_wvalid, w_wvalid;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]       r_csum, w_csum;
    logic             r_csum_err, w_csum_err;
`endif

    // Shift register holds the finished byte for a whole start bit after byte_valid.
    always_comb w_waddr_inc = (r_waddr == LAST_ADDR) ? '0 : r_waddr + MALEN'(4);

    always_comb begin
        w_ld_next  = r_ld_state;
        w_count    = r_count;
        w_idx      = r_idx;
        w_wbuf     = r_wbuf;
        w_waddr    = r_wvalid ? w_waddr_inc : r_waddr;
        w_wdata    = r_wdata;
        w_wvalid   = 1'b0;
        w_busy     = r_busy;
        w_done     = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        w_csum     = r_csum;
        w_csum_err = 1'b0;
`endif
        unique case (r_ld_state)
            LD_IDLE: if (i_arm && !r_done) begin
                w_ld_next = LD_LEN0;
                w_busy    = 1'b1;
                w_waddr   = '0;
                w_idx     = 2'd0;
                w_count   = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                w_csum    = '0;
`endif
            end
            LD_LEN0: if (r_byte_valid) begin
                w_count[7:0] = r_shift;
                w_ld_next    = LD_LEN1;
            end
            LD_LEN1: if (r_byte_valid) begin
                w_count   = {r_shift, r_count[7:0]};
                w_ld_next = ({r_shift, r_count[7:0]} == 16'd0) ? LD_TAIL : LD_DATA;
            end
            LD_DATA: if (r_byte_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
                w_csum = r_csum ^ r_shift;
`endif
                w_idx = r_idx + 2'd1;
                unique case (r_idx)
                    2'd0: w_wbuf[7:0]   = r_shift;
                    2'd1: w_wbuf[15:8]  = r_shift;
                    2'd2: w_wbuf[23:16] = r_shift;
                    default: begin
                        w_wvalid = 1'b1;
                        w_wdata  = {r_shift, r_wbuf};
                        w_count  = r_count - 16'd1;
                        if (r_count == 16'd1) w_ld_next = LD_TAIL;
                    end
                endcase
            end
`ifdef UART_LOADER_CHECKSUM_EN
            LD_CSUM: if (r_byte_valid) begin
                if (r_shift == r_csum) begin
                    w_ld_next = LD_DONE;
                end else begin
                    w_csum_err = 1'b1;
                    w_busy     = 1'b0;
                    w_ld_next  = LD_IDLE;
                end
            end
`endif
            LD_DONE: begin
                w_done    = 1'b1;
                w_busy    = 1'b0;
                w_ld_next = LD_IDLE;
            end
            default: w_ld_next = LD_IDLE;
        endcase

        // A broken frame abandons the image; the unfinished word is never written.
        if (r_frame_err && r_ld_state != LD_IDLE && r_ld_state != LD_DONE) begin
            w_ld_next = LD_IDLE;
            w_busy    = 1'b0;
            w_wvalid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ld_state <= LD_IDLE;
            r_count    <= '0;
            r_idx      <= '0;
            r_wbuf     <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_wvalid   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum     <= '0;
            r_csum_err <= 1'b0;
`endif
        end else begin
            r_ld_state <= w_ld_next;
            r_count    <= w_count;
            r_idx      <= w_idx;
            r_wbuf     <= w_wbuf;
            r_waddr    <= w_waddr;
            r_wdata    <= w_wdata;
            r_wvalid   <= w_wvalid;
            r_busy     <= w_busy;
            r_done     <= w_done;
`ifdef UART_LOADER_CHECKSUM_EN
            r_csum     <= w_csum;
            r_csum_err <= w_csum_err;
`endif
        end
    end

    assign o_wvalid    = r_wvalid;
    assign o_waddr     = r_waddr;
    assign o_wdata     = r_wdata;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_frame_err = r_frame_err;
`ifdef UART_LOADER_CHECKSUM_EN
    assign o_csum_err  = r_csum_err;
`endif

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial stimulus, write scoreboard, pulse counters.
// Honours `define UART_LOADER_CHECKSUM_EN when the DUT is built with it.
module tb_uart_loader;

    localparam int CPB   = 8;
    localparam int MLEN  = 16;
    localparam int MALEN = 4;

    logic             clk  = 1'b0;
    logic             rstn = 1'b0;
    logic             i_rx = 1'b1;
    logic             i_arm = 1'b0;
    logic             o_wvalid;
    logic [MALEN-1:0] o_waddr;
    logic [31:0]      o_wdata;
    logic             o_busy;
    logic             o_done;
    logic             o_frame_err;
`ifdef UART_LOADER_CHECKSUM_EN
    logic             o_csum_err;
`endif

    uart_loader #(.CLKS_PER_BIT(CPB), .MLEN(MLEN), .MALEN(MALEN)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_rx       (i_rx),
        .i_arm      (i_arm),
        .o_wvalid   (o_wvalid),
        .o_waddr    (o_waddr),
        .o_wdata    (o_wdata),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_frame_err(o_frame_err)
`ifdef UART_LOADER_CHECKSUM_EN
        ,
        .o_csum_err (o_csum_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [MALEN-1:0] addr;
        logic [31:0]      data;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  exp_wr;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;
    int   n_done   = 0;
    int   n_ferr   = 0;
    int   n_cerr   = 0;
    logic prev_wvalid = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write is popped and compared as the DUT emits it.
    always @(negedge clk) begin
        if (rstn) begin
            if (o_wvalid) begin
                n_writes++;
                check("wvalid_single_cycle", {63'd0, prev_wvalid}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {63'd0, o_wvalid}, 64'd0);
                end else begin
                    exp_wr = exp_q.pop_front();
                    check("waddr", {60'd0, o_waddr}, {60'd0, exp_wr.addr});
                    check("wdata", {32'd0, o_wdata}, {32'd0, exp_wr.data});
                end
            end
            if (o_done) begin
                n_done++;
                check("busy_low_at_done", {63'd0, o_busy}, 64'd0);
`ifndef UART_LOADER_CHECKSUM_EN
                check("done_after_last_write", {63'd0, prev_wvalid}, 64'd1);
`endif
            end
            if (o_frame_err) n_ferr++;
`ifdef UART_LOADER_CHECKSUM_EN
            if (o_csum_err) n_cerr++;
`endif
        end
        prev_wvalid = o_wvalid;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        i_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        i_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        i_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic arm();
        @(negedge clk);
        i_arm = 1'b1;
        @(negedge clk);
        i_arm = 1'b0;
    endtask

    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

    initial begin
        int          w0, d0, f0, c0;
        logic [31:0] word;
        logic [7:0]  csum;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_wvalid",    {63'd0, o_wvalid},    64'd0);
        check("rst_busy",      {63'd0, o_busy},      64'd0);
        check("rst_done",      {63'd0, o_done},      64'd0);
        check("rst_frame_err", {63'd0, o_frame_err}, 64'd0);
        check("rst_waddr",     {60'd0, o_waddr},     64'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Basic two-word image
        w0 = n_writes; d0 = n_done;
        arm();
        check("busy_after_arm", {63'd0, o_busy}, 64'd1);
        exp_q.push_back('{addr: 4'h0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 4'h4, data: 32'h0000_006F});
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h0000_0013);
        send_word(32'h0000_006F);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(8'h7C, 1'b1);
`endif
        repeat (4 * CPB) @(negedge clk);
        check("basic_writes", 64'(n_writes - w0), 64'd2);
        check("basic_done",   64'(n_done - d0),   64'd1);
        check("basic_busy",   {63'd0, o_busy},    64'd0);
        check("basic_queue",  64'(exp_q.size()),  64'd0);

        // Bytes without arming are dropped
        w0 = n_writes; d0 = n_done;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h5A, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check("unarmed_busy",   {63'd0, o_busy},   64'd0);
        check("unarmed_writes", 64'(n_writes - w0), 64'd0);
        check("unarmed_done",   64'(n_done - d0),   64'd0);

        // Framing error aborts the load
        w0 = n_writes; d0 = n_done; f0 = n_ferr;
        arm();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        check("abort_busy_before", {63'd0, o_busy}, 64'd1);
        send_byte(8'h55, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        check("abort_frame_err", 64'(n_ferr - f0),   64'd1);
        check("abort_busy",      {63'd0, o_busy},    64'd0);
        check("abort_writes",    64'(n_writes - w0), 64'd0);
        check("abort_done",      64'(n_done - d0),   64'd0);

        // Address wrap: five words into a 16-byte memory
        w0 = n_writes; d0 = n_done;
        csum = 8'h00;
        arm();
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 5; k++) begin
            word = 32'hA0B0_C000 + 32'(k * 32'h0101);
            csum = csum ^ xor_bytes(word);
            exp_q.push_back('{addr: MALEN'((4 * k) % MLEN), data: word});
            send_word(word);
        end
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(csum, 1'b1);
`endif
        repeat (4 * CPB) @(negedge clk);
        check("wrap_writes", 64'(n_writes - w0), 64'd5);
        check("wrap_done",   64'(n_done - d0),   64'd1);
        check("wrap_queue",  64'(exp_q.size()),  64'd0);

        // Reset in the middle of a word, then reload
        arm();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h99, 1'b1);
        send_byte(8'h88, 1'b1);
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_busy",   {63'd0, o_busy},   64'd0);
        check("midrst_wvalid", {63'd0, o_wvalid}, 64'd0);
        check("midrst_waddr",  {60'd0, o_waddr},  64'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        w0 = n_writes; d0 = n_done;
        arm();
        exp_q.push_back('{addr: 4'h0, data: 32'hEFBE_ADDE});
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'hEFBE_ADDE);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(xor_bytes(32'hEFBE_ADDE), 1'b1);
`endif
        repeat (4 * CPB) @(negedge clk);
        check("reload_writes", 64'(n_writes - w0), 64'd1);
        check("reload_done",   64'(n_done - d0),   64'd1);

`ifdef UART_LOADER_CHECKSUM_EN
        // Wrong checksum: word is written, then the load fails
        w0 = n_writes; d0 = n_done; c0 = n_cerr;
        arm();
        exp_q.push_back('{addr: 4'h0, data: 32'h4433_2211});
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_word(32'h4433_2211);
        send_byte(8'h00, 1'b1);
        repeat (4 * CPB) @(negedge clk);
        check("csum_writes", 64'(n_writes - w0), 64'd1);
        check("csum_err",    64'(n_cerr - c0),   64'd1);
        check("csum_done",   64'(n_done - d0),   64'd0);
        check("csum_busy",   {63'd0, o_busy},    64'd0);
`else
        c0 = n_cerr;
        check("no_csum_err", 64'(n_cerr - c0), 64'd0);
`endif

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
